// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared types and register map for the dead-time gate
package servo_pkg;

    // Per-phase gate state.
    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_UON  = 2'd1,
        PH_LON  = 2'd2
    } phase_state_t;

    localparam logic [1:0] DTG_ADDR_DEADTIME = 2'd0;
    localparam logic [1:0] DTG_ADDR_ENABLE   = 2'd1;
    localparam logic [1:0] DTG_ADDR_FAULTCLR = 2'd2;

endpackage

// File: rtl/deadtime_phase.sv
// rtl/deadtime_phase.sv - one half-bridge phase: gate FSM plus dead-time counter
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   req_u, req_l    decoded exclusive high/low-side requests
//   block           forces the phase off and inhibits turn-on
//   deadtime        countdown value loaded whenever a gate turns off
//   ugate, lgate    registered gate commands (mutually exclusive)
module deadtime_phase
    import servo_pkg::*;
#(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_u,
    input  logic                req_l,
    input  logic                block,
    input  logic [DT_WIDTH-1:0] deadtime,
    output logic                ugate,
    output logic                lgate
);

    phase_state_t        state, state_next;
    logic [DT_WIDTH-1:0] cnt, cnt_next;
    logic                ugate_next, lgate_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PH_IDLE;
            cnt   <= '0;
            ugate <= 1'b0;
            lgate <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ugate <= ugate_next;
            lgate <= lgate_next;
        end
    end

    // The counter only runs in IDLE, and the request seen when it reaches
    // zero decides the next state; request changes never restart it.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            PH_IDLE: begin
                if (cnt != '0) begin
                    cnt_next = cnt - DT_WIDTH'(1);
                end else if (!block && req_u) begin
                    state_next = PH_UON;
                end else if (!block && req_l) begin
                    state_next = PH_LON;
                end
            end
            PH_UON: begin
                if (!req_u || block) begin
                    state_next = PH_IDLE;
                    cnt_next   = deadtime;
                end
            end
            PH_LON: begin
                if (!req_l || block) begin
                    state_next = PH_IDLE;
                    cnt_next   = deadtime;
                end
            end
            default: begin
                state_next = PH_IDLE;
                cnt_next   = deadtime;
            end
        endcase
    end

    // Gate commands are decoded from the next state and registered, so the
    // pins come straight off flops and can never be high together.
    always_comb begin
        ugate_next = (state_next == PH_UON);
        lgate_next = (state_next == PH_LON);
    end

endmodule

// File: rtl/deadtime_gate.sv
// rtl/deadtime_gate.sv - dead-time insertion and fault gating between PWM and gate drivers
//
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   MMS_addr/MMS_write/MMS_writedata    write-only register slave
//   Udrive_in, Ldrive_in                raw modulator compare outputs
//   fault_n                             asynchronous active-low overcurrent input
//   Ugate, Lgate                        registered gate commands
//   fault_latched                       sticky fault status
//   irqout                              one-cycle pulse on fault entry
module deadtime_gate
    import servo_pkg::*;
#(
    parameter int NPHASE   = 3,
    parameter int DT_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        MMS_addr,
    input  logic              MMS_write,
    input  logic [31:0]       MMS_writedata,
    input  logic [NPHASE-1:0] Udrive_in,
    input  logic [NPHASE-1:0] Ldrive_in,
    input  logic              fault_n,
    output logic [NPHASE-1:0] Ugate,
    output logic [NPHASE-1:0] Lgate,
    output logic              fault_latched,
    output logic              irqout
);

    logic [DT_WIDTH-1:0] deadtime;
    logic                enable;
    logic                fault_meta, fault_sync;
    logic                fault_act;
    logic                clear_wr;
    logic                block;
    logic [NPHASE-1:0]   req_u, req_l;
    logic                unused_wdata;

    assign unused_wdata = ^MMS_writedata[31:DT_WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deadtime <= '1;
            enable   <= 1'b0;
        end else if (MMS_write) begin
            if (MMS_addr == DTG_ADDR_DEADTIME) deadtime <= MMS_writedata[DT_WIDTH-1:0];
            if (MMS_addr == DTG_ADDR_ENABLE)   enable   <= MMS_writedata[0];
        end
    end

    // Synchronizer flops idle high (no fault) out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_meta <= 1'b1;
            fault_sync <= 1'b1;
        end else begin
            fault_meta <= fault_n;
            fault_sync <= fault_meta;
        end
    end

    assign fault_act = ~fault_sync;
    assign clear_wr  = MMS_write && (MMS_addr == DTG_ADDR_FAULTCLR) && MMS_writedata[0];

    // An active fault always wins over a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_latched <= 1'b0;
            irqout        <= 1'b0;
        end else begin
            irqout <= fault_act & ~fault_latched;
            if (fault_act)     fault_latched <= 1'b1;
            else if (clear_wr) fault_latched <= 1'b0;
        end
    end

    assign block = fault_latched | fault_act | ~enable;
    assign req_u = Udrive_in & ~Ldrive_in;
    assign req_l = Ldrive_in & ~Udrive_in;

    for (genvar g = 0; g < NPHASE; g++) begin : g_phase
        deadtime_phase #(
            .DT_WIDTH (DT_WIDTH)
        ) u_phase (
            .clk      (clk),
            .reset    (reset),
            .req_u    (req_u[g]),
            .req_l    (req_l[g]),
            .block    (block),
            .deadtime (deadtime),
            .ugate    (Ugate[g]),
            .lgate    (Lgate[g])
        );
    end

endmodule

// File: tb/tb_deadtime_gate.sv
// tb/tb_deadtime_gate.sv - self-checking bench for deadtime_gate
module tb_deadtime_gate;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  MMS_addr = '0;
    logic        MMS_write = 1'b0;
    logic [31:0] MMS_writedata = '0;
    logic [2:0]  Udrive_in = '0;
    logic [2:0]  Ldrive_in = '0;
    logic        fault_n = 1'b1;
    logic [2:0]  Ugate, Lgate;
    logic        fault_latched, irqout;

    int nchk = 0;
    int nerr = 0;

    // Reference model: each phase is "off", "U on" or "L on"; a turn-off at
    // edge n forbids any turn-on before edge n+deadtime+1.
    int mode [3];
    int ready_at [3];
    int cyc;
    bit hist [$];
    int mdt;
    bit men, mfl, mirq;

    deadtime_gate dut (
        .clk           (clk),
        .reset         (reset),
        .MMS_addr      (MMS_addr),
        .MMS_write     (MMS_write),
        .MMS_writedata (MMS_writedata),
        .Udrive_in     (Udrive_in),
        .Ldrive_in     (Ldrive_in),
        .fault_n       (fault_n),
        .Ugate         (Ugate),
        .Lgate         (Lgate),
        .fault_latched (fault_latched),
        .irqout        (irqout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 3; p++) begin
            mode[p]     = 0;
            ready_at[p] = 0;
        end
        cyc = 0;
        hist.delete();
        mdt  = 255;
        men  = 1'b0;
        mfl  = 1'b0;
        mirq = 1'b0;
    endtask

    task automatic tick();
        bit fa, blk, clr, ru, rl;
        logic [2:0] eu, el;
        fa  = (cyc >= 2) && (hist[cyc-2] == 1'b0);
        hist.push_back(fault_n);
        clr = MMS_write && (MMS_addr == 2'd2) && MMS_writedata[0];
        blk = mfl || fa || !men;
        for (int p = 0; p < 3; p++) begin
            ru = Udrive_in[p] && !Ldrive_in[p];
            rl = Ldrive_in[p] && !Udrive_in[p];
            if (mode[p] == 1) begin
                if (!ru || blk) begin mode[p] = 0; ready_at[p] = cyc + mdt + 1; end
            end else if (mode[p] == 2) begin
                if (!rl || blk) begin mode[p] = 0; ready_at[p] = cyc + mdt + 1; end
            end else if (cyc >= ready_at[p] && !blk) begin
                if (ru)      mode[p] = 1;
                else if (rl) mode[p] = 2;
            end
        end
        mirq = fa && !mfl;
        if (fa)       mfl = 1'b1;
        else if (clr) mfl = 1'b0;
        if (MMS_write && MMS_addr == 2'd0) mdt = int'(MMS_writedata[7:0]);
        if (MMS_write && MMS_addr == 2'd1) men = MMS_writedata[0];
        cyc++;
        @(posedge clk);
        #1;
        for (int p = 0; p < 3; p++) begin
            eu[p] = (mode[p] == 1);
            el[p] = (mode[p] == 2);
        end
        chk("ugate", 32'(Ugate), 32'(eu));
        chk("lgate", 32'(Lgate), 32'(el));
        chk("fault_latched", 32'(fault_latched), 32'(mfl));
        chk("irqout", 32'(irqout), 32'(mirq));
        chk("no_overlap", 32'(Ugate & Lgate), 32'd0);
    endtask

    task automatic reg_write(input logic [1:0] addr, input logic [31:0] data);
        MMS_addr      = addr;
        MMS_writedata = data;
        MMS_write     = 1'b1;
        tick();
        MMS_write     = 1'b0;
    endtask

    initial begin
        int n;
        int fcnt;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_ugate", 32'(Ugate), 32'd0);
        chk("reset_lgate", 32'(Lgate), 32'd0);
        chk("reset_fault", 32'(fault_latched), 32'd0);
        chk("reset_irq", 32'(irqout), 32'd0);

        // Dead-time gap with deadtime=5.
        reg_write(2'd0, 32'd5);
        reg_write(2'd1, 32'd1);
        Udrive_in = 3'b001; Ldrive_in = 3'b000;
        repeat (20) tick();
        chk("gap_uon", 32'(Ugate[0]), 32'd1);
        Udrive_in = 3'b000; Ldrive_in = 3'b001;
        tick();
        chk("gap_ufall", 32'(Ugate[0]), 32'd0);
        n = 0;
        while (!Lgate[0] && n < 50) begin tick(); n++; end
        chk("gap_len_dt5", n, 6);

        // Illegal both-high request.
        Udrive_in = 3'b111; Ldrive_in = 3'b000;
        repeat (10) tick();
        chk("illegal_pre", 32'(Ugate), 32'h7);
        Ldrive_in = 3'b111;
        tick();
        chk("illegal_u", 32'(Ugate), 32'd0);
        chk("illegal_l", 32'(Lgate), 32'd0);
        repeat (3) tick();

        // Zero dead-time with a one-cycle glitch.
        reg_write(2'd0, 32'd0);
        Udrive_in = 3'b001; Ldrive_in = 3'b000;
        repeat (3) tick();
        Udrive_in = 3'b000; Ldrive_in = 3'b001;
        tick();
        chk("glitch_gap", 32'(Ugate[0]), 32'd0);
        Udrive_in = 3'b001; Ldrive_in = 3'b000;
        tick();
        chk("glitch_resume", 32'(Ugate[0]), 32'd1);
        repeat (3) tick();

        // Fault entry and clear.
        fault_n = 1'b0;
        tick();
        tick();
        chk("fault_before", 32'(Ugate[0]), 32'd1);
        fault_n = 1'b1;
        tick();
        chk("fault_gate", 32'(Ugate), 32'd0);
        chk("fault_latch", 32'(fault_latched), 32'd1);
        chk("fault_irq", 32'(irqout), 32'd1);
        tick();
        chk("fault_irq_once", 32'(irqout), 32'd0);
        fault_n = 1'b0;
        repeat (3) tick();
        reg_write(2'd2, 32'd1);
        chk("clear_ignored", 32'(fault_latched), 32'd1);
        fault_n = 1'b1;
        repeat (3) tick();
        reg_write(2'd2, 32'd1);
        chk("clear_done", 32'(fault_latched), 32'd0);
        repeat (3) tick();

        // Reconfiguration during a countdown.
        reg_write(2'd0, 32'd10);
        repeat (15) tick();
        Udrive_in = 3'b000; Ldrive_in = 3'b001;
        tick();
        reg_write(2'd0, 32'd2);
        n = 1;
        while (!Lgate[0] && n < 50) begin tick(); n++; end
        chk("reconf_gap11", n, 11);
        Udrive_in = 3'b001; Ldrive_in = 3'b000;
        tick();
        n = 0;
        while (!Ugate[0] && n < 50) begin tick(); n++; end
        chk("reconf_gap3", n, 3);

        // Randomized traffic against the model.
        fcnt = 0;
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < 3; p++) begin
                if ($urandom_range(0, 7) == 0) begin
                    Udrive_in[p] = 1'($urandom_range(0, 1));
                    Ldrive_in[p] = 1'($urandom_range(0, 1));
                end
            end
            if (fcnt > 0) begin
                fcnt--;
                fault_n = (fcnt == 0);
            end else if ($urandom_range(0, 79) == 0) begin
                fcnt = $urandom_range(1, 4);
                fault_n = 1'b0;
            end
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0: reg_write(2'd0, 32'($urandom_range(0, 7)));
                    1: reg_write(2'd1, 32'($urandom_range(0, 9) != 0));
                    2: reg_write(2'd2, 32'd1);
                    default: reg_write(2'd3, $urandom);
                endcase
            end else begin
                tick();
            end
        end

        // Reset during LON, then enable=0 keeps gates low.
        fault_n = 1'b1;
        repeat (3) tick();
        reg_write(2'd2, 32'd1);
        reg_write(2'd0, 32'd0);
        reg_write(2'd1, 32'd1);
        Udrive_in = 3'b000; Ldrive_in = 3'b111;
        repeat (10) tick();
        chk("lon_before_reset", 32'(Lgate), 32'h7);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_l", 32'(Lgate), 32'd0);
        chk("async_reset_u", 32'(Ugate), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk("post_reset_fault", 32'(fault_latched), 32'd0);
        chk("post_reset_irq", 32'(irqout), 32'd0);
        Udrive_in = 3'b101; Ldrive_in = 3'b010;
        repeat (5) tick();
        chk("disabled_u", 32'(Ugate), 32'd0);
        chk("disabled_l", 32'(Lgate), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
